// File: rtl/aes_seq_pkg.sv
// Shared constants and FSM encoding for the AES load sequencer:
// word/block geometry, default core latency and the sequencer states.
package aes_seq_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLK_W           = WORD_W * WORDS_PER_BLOCK;
  localparam int LATENCY_DEFAULT = 21;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/aes_load_seq_if.sv
// Bus between the load sequencer, its word source, the aes_128 core and the
// ciphertext consumer.
interface aes_load_seq_if;
  import aes_seq_pkg::*;

  // Input words: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on sequencer state, never on in_valid; in_sel and
  // in_data are meaningful only while in_valid is high. The result side uses
  // ct_valid/ct_ack the same way: ct is held until a cycle with ct_ack high.
  logic              in_valid;
  logic              in_ready;
  logic              in_sel;
  logic [WORD_W-1:0] in_data;
  logic [BLK_W-1:0]  state;
  logic [BLK_W-1:0]  key;
  logic              launch;
  logic [BLK_W-1:0]  ct_in;
  logic [BLK_W-1:0]  ct;
  logic              ct_valid;
  logic              ct_ack;
  logic              err;

  modport slave (
    input  in_valid, in_sel, in_data, ct_in, ct_ack,
    output in_ready, state, key, launch, ct, ct_valid, err
  );

  modport master (
    output in_valid, in_sel, in_data, ct_in, ct_ack,
    input  in_ready, state, key, launch, ct, ct_valid, err
  );

endinterface

// File: rtl/aes_word_packer.sv
// Assembles four words MSB-first into a block; the index wraps 3->0 so a
// partial reload overwrites only the words it actually writes.
module aes_word_packer
  import aes_seq_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [4*DATA_W-1:0]   blk_o,
  output logic [1:0]            idx_o,
  output logic                  last_o
);

  logic [4*DATA_W-1:0] blk_q, blk_d;
  logic [1:0]          idx_q, idx_d;

  always_comb begin
    blk_d = blk_q;
    idx_d = idx_q;
    if (we_i) begin
      case (idx_q)
        2'd0:    blk_d[4*DATA_W-1 -: DATA_W] = data_i;
        2'd1:    blk_d[3*DATA_W-1 -: DATA_W] = data_i;
        2'd2:    blk_d[2*DATA_W-1 -: DATA_W] = data_i;
        default: blk_d[DATA_W-1   -: DATA_W] = data_i;
      endcase
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q <= '0;
      idx_q <= '0;
    end else begin
      blk_q <= blk_d;
      idx_q <= idx_d;
    end
  end

  assign blk_o  = blk_q;
  assign idx_o  = idx_q;
  assign last_o = (idx_q == 2'd3);

endmodule

// File: rtl/aes_load_seq.sv
// Loads key and plaintext words for an aes_128 core, launches an encryption
// once both blocks are complete and captures the ciphertext after LATENCY.
module aes_load_seq
  import aes_seq_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEFAULT,
  parameter int WORD_W  = aes_seq_pkg::WORD_W
) (
  input  logic          clk,
  input  logic          rst,
  aes_load_seq_if.slave bus,
  output fsm_state_t    dbg_fsm_o
);

  localparam int PACK_W = 4 * WORD_W;
  localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  fsm_state_t         fsm_q, fsm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PACK_W-1:0]  state_q, state_d;
  logic [PACK_W-1:0]  ct_q, ct_d;
  logic               ct_valid_q, ct_valid_d;
  logic               launch_q, launch_d;
  logic               err_q, err_d;
  logic               key_full_q, key_full_d;

  logic               accept;
  logic               key_we, pt_we;
  logic [PACK_W-1:0]  key_blk, pt_blk;
  logic [1:0]         key_idx, pt_idx;
  logic               key_last, pt_last;

  assign accept = bus.in_valid && (fsm_q == ST_LOAD);
  assign key_we = accept && !bus.in_sel;
  assign pt_we  = accept && bus.in_sel;

  aes_word_packer #(.DATA_W(WORD_W)) u_key_packer (
    .clk    (clk),
    .rst    (rst),
    .we_i   (key_we),
    .data_i (bus.in_data),
    .blk_o  (key_blk),
    .idx_o  (key_idx),
    .last_o (key_last)
  );

  aes_word_packer #(.DATA_W(WORD_W)) u_pt_packer (
    .clk    (clk),
    .rst    (rst),
    .we_i   (pt_we),
    .data_i (bus.in_data),
    .blk_o  (pt_blk),
    .idx_o  (pt_idx),
    .last_o (pt_last)
  );

  always_comb begin
    fsm_d      = fsm_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    ct_d       = ct_q;
    ct_valid_d = ct_valid_q;
    key_full_d = key_full_q;
    launch_d   = 1'b0;
    err_d      = 1'b0;

    if (key_we && key_last) begin
      key_full_d = 1'b1;
    end

    case (fsm_q)
      ST_LOAD: begin
        // The 4th plaintext word is still on in_data, not yet in the packer.
        if (pt_we && pt_last) begin
          if (key_full_q) begin
            state_d  = {pt_blk[PACK_W-1:WORD_W], bus.in_data};
            launch_d = 1'b1;
            cnt_d    = LAT_M1;
            fsm_d    = ST_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          ct_d       = bus.ct_in;
          ct_valid_d = 1'b1;
          fsm_d      = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.ct_ack) begin
          ct_valid_d = 1'b0;
          fsm_d      = ST_LOAD;
        end
      end
      default: begin
        fsm_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= ST_LOAD;
      cnt_q      <= '0;
      state_q    <= '0;
      ct_q       <= '0;
      ct_valid_q <= 1'b0;
      launch_q   <= 1'b0;
      err_q      <= 1'b0;
      key_full_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      ct_q       <= ct_d;
      ct_valid_q <= ct_valid_d;
      launch_q   <= launch_d;
      err_q      <= err_d;
      key_full_q <= key_full_d;
    end
  end

  assign bus.in_ready = (fsm_q == ST_LOAD);
  assign bus.state    = state_q;
  assign bus.key      = key_blk;
  assign bus.launch   = launch_q;
  assign bus.ct       = ct_q;
  assign bus.ct_valid = ct_valid_q;
  assign bus.err      = err_q;
  assign dbg_fsm_o    = fsm_q;

endmodule

// File: tb/tb_aes_load_seq.sv
// Directed-plus-random bench for aes_load_seq with a word-list reference
// model and a stand-in aes_128 that presents the ciphertext at LATENCY.
module tb_aes_load_seq;
  import aes_seq_pkg::*;

  localparam int LAT = 21;
  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  fsm_state_t dbg_fsm;
  always #5 clk = ~clk;

  aes_load_seq_if ifc ();

  aes_load_seq #(.LATENCY(LAT), .WORD_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc.slave),
    .dbg_fsm_o (dbg_fsm)
  );

  int tests = 0;
  int fails = 0;

  // reference model: plain word lists per target
  logic [31:0]  m_kw [4];
  logic [31:0]  m_pw [4];
  int           m_kidx, m_pidx;
  bit           m_key_full;
  bit           launched;
  logic [127:0] m_state;
  logic [127:0] exp_q [$];

  function automatic logic [127:0] words2blk(input logic [31:0] w [4]);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int i);
    logic [127:0] t;
    t = blk >> (32 * (3 - i));
    return t[31:0];
  endfunction

  // Stand-in cipher: the known-answer vector, otherwise a fixed keyed mix.
  function automatic logic [127:0] fake_aes(input logic [127:0] pt, input logic [127:0] k);
    if (pt == PT0 && k == K0) return CT0;
    return {pt[63:0], pt[127:64]} ^ k ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_1234_8765;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_kw[i] = '0;
      m_pw[i] = '0;
    end
    m_kidx = 0;
    m_pidx = 0;
    m_key_full = 0;
    launched = 0;
    m_state = '0;
    exp_q.delete();
  endtask

  // stand-in aes_128 output: valid only in the cycle the result is due
  int cyc = -1;
  initial begin
    ifc.ct_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) cyc = -1;
      else if (ifc.launch) cyc = 0;
      else if (cyc >= 0) cyc++;
      if (cyc == LAT - 1) begin
        ifc.ct_in = fake_aes(ifc.state, ifc.key);
        cyc = -1;
      end else begin
        ifc.ct_in = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // called #1 after the edge where a word was accepted
  task automatic model_accept(input bit sel, input logic [31:0] data);
    if (!sel) begin
      m_kw[m_kidx] = data;
      m_kidx = (m_kidx + 1) % 4;
      if (m_kidx == 0) m_key_full = 1;
      chk("key_word", ifc.key, words2blk(m_kw));
    end else begin
      m_pw[m_pidx] = data;
      m_pidx = (m_pidx + 1) % 4;
      if (m_pidx == 0 && m_key_full) begin
        m_state = words2blk(m_pw);
        exp_q.push_back(fake_aes(m_state, words2blk(m_kw)));
        launched = 1;
        chk("launch", 128'(ifc.launch), 128'(1));
        chk("state", ifc.state, m_state);
        chk("err_on_launch", 128'(ifc.err), 128'(0));
        chk("fsm_wait", 128'(dbg_fsm), 128'(ST_WAIT));
      end else if (m_pidx == 0) begin
        chk("err_pulse", 128'(ifc.err), 128'(1));
        chk("no_launch_err", 128'(ifc.launch), 128'(0));
        chk("ready_after_err", 128'(ifc.in_ready), 128'(1));
        chk("state_kept_err", ifc.state, m_state);
      end else begin
        chk("no_launch_mid", 128'(ifc.launch), 128'(0));
      end
    end
  endtask

  // driver: random idle gaps with junk in_sel/in_data, then offer the word
  task automatic send_word(input bit sel, input logic [31:0] data);
    int gap;
    bit acc;
    gap = $urandom_range(0, 2);
    acc = 0;
    repeat (gap) begin
      ifc.in_valid = 1'b0;
      ifc.in_sel   = 1'($urandom);
      ifc.in_data  = $urandom;
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b1;
    ifc.in_sel   = sel;
    ifc.in_data  = data;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = ifc.in_ready;
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    chk("accept_timeout", 128'(acc), 128'(1));
    if (acc) model_accept(sel, data);
  endtask

  task automatic send_block(input bit sel, input logic [127:0] blk);
    for (int i = 0; i < 4; i++) send_word(sel, word_of(blk, i));
  endtask

  // wait for the result, hold it for 'hold' cycles, then acknowledge
  task automatic finish_block(input int hold);
    int n;
    int wait_bad;
    int hold_bad;
    logic [127:0] exp;
    n = 0;
    wait_bad = 0;
    hold_bad = 0;
    launched = 0;
    while (!ifc.ct_valid && n < LAT + 50) begin
      ifc.ct_ack = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
      if (ifc.launch || ifc.key !== words2blk(m_kw) || ifc.state !== m_state) wait_bad++;
      if (!ifc.ct_valid && ifc.in_ready) wait_bad++;
    end
    ifc.ct_ack = 1'b0;
    chk("ct_latency", 128'(n), 128'(LAT));
    chk("wait_stable", 128'(wait_bad), 128'(0));
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 128'(exp_q.size()), 128'(1));
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    chk("ct", ifc.ct, exp);
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (ifc.ct !== exp || ifc.ct_valid !== 1'b1 || ifc.in_ready !== 1'b0) hold_bad++;
      if (ifc.key !== words2blk(m_kw) || ifc.state !== m_state) hold_bad++;
    end
    chk("done_hold", 128'(hold_bad), 128'(0));
    ifc.ct_ack = 1'b1;
    @(posedge clk);
    #1;
    ifc.ct_ack = 1'b0;
    chk("ack_ct_valid", 128'(ifc.ct_valid), 128'(0));
    chk("ack_ready", 128'(ifc.in_ready), 128'(1));
    chk("ack_ct_kept", ifc.ct, exp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, ifc.state, '0);
    chk({tag, "_key"}, ifc.key, '0);
    chk({tag, "_ct"}, ifc.ct, '0);
    chk({tag, "_flags"}, 128'({ifc.launch, ifc.ct_valid, ifc.err}), 128'(0));
    chk({tag, "_fsm"}, 128'(dbg_fsm), 128'(ST_LOAD));
  endtask

  initial begin
    bit sels [$];
    int nk;
    int bad;
    logic [127:0] blk;

    ifc.in_valid = 1'b0;
    ifc.in_sel   = 1'b0;
    ifc.in_data  = '0;
    ifc.ct_ack   = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 128'(ifc.in_ready), 128'(1));

    // plaintext before any key: error pulse, no launch
    send_block(1'b1, {$urandom, $urandom, $urandom, $urandom});
    @(posedge clk);
    #1;
    chk("err_one_cycle", 128'(ifc.err), 128'(0));
    chk("no_launch_after_err", 128'(ifc.launch), 128'(0));
    chk("ready_still", 128'(ifc.in_ready), 128'(1));

    // known-answer vector, held in DONE for 50 cycles
    send_block(1'b0, K0);
    send_block(1'b1, PT0);
    chk("kat_launched", 128'(launched), 128'(1));
    finish_block(50);

    // second plaintext with the key retained
    send_block(1'b1, {$urandom, $urandom, $urandom, $urandom});
    finish_block(2);
    chk("key_retained", ifc.key, K0);

    // reset while WAIT counter is at 10
    send_block(1'b0, {$urandom, $urandom, $urandom, $urandom});
    send_block(1'b1, {$urandom, $urandom, $urandom, $urandom});
    repeat (LAT - 1 - 10) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid_wait_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("ready_after_rst2", 128'(ifc.in_ready), 128'(1));
    bad = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (ifc.ct_valid || ifc.launch || !ifc.in_ready) bad++;
    end
    chk("no_ct_after_reset", 128'(bad), 128'(0));
    send_block(1'b0, {$urandom, $urandom, $urandom, $urandom});
    blk = {$urandom, $urandom, $urandom, $urandom};
    send_block(1'b1, blk);
    finish_block($urandom_range(0, 3));

    // interleaved key/plaintext words with random partial key reloads
    for (int b = 0; b < 8; b++) begin
      sels.delete();
      nk = $urandom_range(0, 6);
      repeat (nk) sels.push_back(1'b0);
      repeat (4) sels.push_back(1'b1);
      for (int i = sels.size() - 1; i > 0; i--) begin
        int j;
        bit t;
        j = $urandom_range(0, i);
        t = sels[i];
        sels[i] = sels[j];
        sels[j] = t;
      end
      foreach (sels[i]) begin
        send_word(sels[i], $urandom);
        if (launched) finish_block($urandom_range(0, 3));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_load_seq.md
AES_LOAD_SEQ -- requirements
Module: aes_load_seq

Interface
REQ-001 Parameter LATENCY, default 21: cycles from launch to a valid aes_128 ciphertext on ct_in.
REQ-002 Parameter WORD_W, default 32: input word width; fixed at 32, other values unsupported.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  input word offered.
REQ-006 in_ready  output  1  input word can be accepted.
REQ-007 in_sel  input  1  word target: 0 = key, 1 = plaintext.
REQ-008 in_data  input  32  input word.
REQ-009 state  output  128  plaintext presented to aes_128.
REQ-010 key  output  128  key presented to aes_128.
REQ-011 launch  output  1  one-cycle pulse; state/key valid for a new encryption.
REQ-012 ct_in  input  128  ciphertext from aes_128 out.
REQ-013 ct  output  128  captured ciphertext.
REQ-014 ct_valid  output  1  ct holds a result.
REQ-015 ct_ack  input  1  consumer has taken ct.
REQ-016 err  output  1  one-cycle pulse; plaintext completed without a full key.

Function
REQ-017 Word accepted when in_valid && in_ready; in_ready = 1 only in LOAD state.
REQ-018 Words are MSB-first: the 1st word of a target goes to [127:96], the 4th to [31:0]; a separate 2-bit counter per target wraps 3->0.
REQ-019 key_full flag sets on acceptance of the 4th key word and stays set until reset.
REQ-020 Partial key reload overwrites only the accepted words; the previous key stays in place otherwise.
REQ-021 FSM states: LOAD, WAIT, DONE.
REQ-022 In LOAD, acceptance of the 4th plaintext word with key_full = 1: state updates; next cycle launch = 1, FSM -> WAIT.
REQ-023 In LOAD, acceptance of the 4th plaintext word with key_full = 0: err = 1 next cycle, no launch, FSM stays in LOAD, plaintext counter returns to 0.
REQ-024 In WAIT, a down-counter loaded with LATENCY-1 on launch decrements each cycle.
REQ-025 WAIT at count 0: ct <= ct_in, ct_valid = 1 on the next cycle, FSM -> DONE; ct_valid rises exactly LATENCY cycles after the launch cycle.
REQ-026 state and key are stable from launch until DONE exits.
REQ-027 In DONE, ct and ct_valid hold until ct_ack = 1.
REQ-028 ct_ack = 1 in DONE: ct_valid = 0 and FSM -> LOAD next cycle; ct retains its last value.
REQ-029 ct_ack outside DONE is ignored.
REQ-030 in_sel changing mid-target does not reset the other target's counter.
REQ-031 LATENCY = 1: ct captured in the cycle after launch.

Reset
REQ-032 rst = 1 at any time, including mid-WAIT or DONE, sets: FSM = LOAD; counters = 0; key_full = 0; state = key = ct = 0; launch = ct_valid = err = 0.
REQ-033 in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-034 Shared package aes_seq_pkg holds: WORD_W, WORDS_PER_BLOCK = 4, default LATENCY, FSM state enum.
REQ-035 One sub-module, aes_word_packer: 128-bit MSB-first word register with write-enable, 2-bit index, last-word flag; instantiated twice (key, plaintext).

Verification
REQ-036 Key 000102030405060708090a0b0c0d0e0f, then plaintext 00112233445566778899aabbccddeeff -> launch once; ct = 69c4e0d86a7b0430d8cdb78070b4c55a with ct_valid exactly 21 cycles after launch.
REQ-037 Plaintext words before any key -> err pulse, no launch, in_ready stays 1.
REQ-038 ct_ack held 0 for 50 cycles in DONE -> ct and ct_valid stable, in_ready = 0; ct_ack = 1 -> LOAD next cycle.
REQ-039 Second plaintext with the key retained (no reload) -> correct ciphertext, key unchanged.
REQ-040 rst pulse at WAIT count 10 -> all outputs 0, no ct_valid; full reload then produces correct ct.
REQ-041 in_valid toggled randomly and in_sel interleaved (key word 2, plaintext word 1, ...) -> assembled blocks match reference model.
